// File: rtl/divisor_nr_if.sv
`default_nettype none
// ============================================================================
//  Module   : divisor_nr_if
//  Purpose  : Start/busy/done handshake and operand/result bus of divisor_nr.
//  Revision : 1.0 - initial release
// ============================================================================
interface divisor_nr_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             overflow;

    modport master (
        output start, signed_mode, x, y,
        input  busy, done, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  start, signed_mode, x, y,
        output busy, done, quotient, remainder, div_zero, overflow
    );
endinterface
`default_nettype wire

// File: rtl/divisor_nr.sv
`default_nettype none
// ============================================================================
//  Module   : divisor_nr
//  Purpose  : Multi-cycle non-restoring signed/unsigned integer divider.
//  Revision : 1.0 - initial release
// ============================================================================
module divisor_nr #(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    divisor_nr_if.slave bus
);
    localparam int               c_cnt_w    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state,    w_state;
    logic [WIDTH:0]     r_a,        w_a;
    logic [WIDTH-1:0]   r_mq,       w_mq;
    logic [WIDTH-1:0]   r_b,        w_b;
    logic [WIDTH-1:0]   r_x,        w_x;
    logic [c_cnt_w-1:0] r_cnt,      w_cnt;
    logic               r_neg_q,    w_neg_q;
    logic               r_neg_r,    w_neg_r;
    logic               r_dz_pend,  w_dz_pend;
    logic               r_ovf_pend, w_ovf_pend;
    logic               r_busy,     w_busy;
    logic               r_done,     w_done;
    logic [WIDTH-1:0]   r_quot,     w_quot;
    logic [WIDTH-1:0]   r_rem,      w_rem;
    logic               r_dz,       w_dz;
    logic               r_ovf,      w_ovf;

    logic               w_sm, w_x_neg, w_y_neg;
    logic [WIDTH-1:0]   w_x_mag, w_y_mag, w_q_fix, w_r_fix;
    logic [WIDTH:0]     w_a_sh, w_a_step, w_a_fix;

    assign w_sm    = bus.signed_mode & (SIGNED_EN != 0);
    assign w_x_neg = w_sm & bus.x[WIDTH-1];
    assign w_y_neg = w_sm & bus.y[WIDTH-1];
    assign w_x_mag = w_x_neg ? -bus.x : bus.x;
    assign w_y_mag = w_y_neg ? -bus.y : bus.y;

    // A wraps modulo 2^(WIDTH+1) mid-step, but each settled value lies in [-B, B)
    assign w_a_sh   = {r_a[WIDTH-1:0], r_mq[WIDTH-1]};
    assign w_a_step = r_a[WIDTH] ? (w_a_sh + {1'b0, r_b}) : (w_a_sh - {1'b0, r_b});
    assign w_a_fix  = r_a[WIDTH] ? (r_a + {1'b0, r_b}) : r_a;
    assign w_q_fix  = r_neg_q ? -r_mq : r_mq;
    assign w_r_fix  = r_neg_r ? -w_a_fix[WIDTH-1:0] : w_a_fix[WIDTH-1:0];

    always_comb begin
        w_state    = r_state;
        w_a        = r_a;
        w_mq       = r_mq;
        w_b        = r_b;
        w_x        = r_x;
        w_cnt      = r_cnt;
        w_neg_q    = r_neg_q;
        w_neg_r    = r_neg_r;
        w_dz_pend  = r_dz_pend;
        w_ovf_pend = r_ovf_pend;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_quot     = r_quot;
        w_rem      = r_rem;
        w_dz       = r_dz;
        w_ovf      = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_a        = '0;
                    w_mq       = w_x_mag;
                    w_b        = w_y_mag;
                    w_x        = bus.x;
                    w_cnt      = '0;
                    w_neg_q    = w_x_neg ^ w_y_neg;
                    w_neg_r    = w_x_neg;
                    w_dz_pend  = (bus.y == '0);
                    w_ovf_pend = w_sm && (bus.x == c_most_neg) && (bus.y == '1);
                    w_busy     = 1'b1;
                    w_state    = (w_dz_pend || w_ovf_pend) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                w_a  = w_a_step;
                w_mq = {r_mq[WIDTH-2:0], ~w_a_step[WIDTH]};
                if (r_cnt == c_cnt_w'(WIDTH - 1)) begin
                    w_state = S_FIX;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_FIX: begin
                // Special cases arrive with cnt=0 and linger one extra cycle here
                if ((r_dz_pend || r_ovf_pend) && (r_cnt == '0)) begin
                    w_cnt = 1'b1;
                end else begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_dz    = r_dz_pend;
                    w_ovf   = r_ovf_pend;
                    if (r_dz_pend) begin
                        w_quot = '1;
                        w_rem  = r_x;
                    end else if (r_ovf_pend) begin
                        w_quot = c_most_neg;
                        w_rem  = '0;
                    end else begin
                        w_quot = w_q_fix;
                        w_rem  = w_r_fix;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_mq       <= '0;
            r_b        <= '0;
            r_x        <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz_pend  <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_a        <= w_a;
            r_mq       <= w_mq;
            r_b        <= w_b;
            r_x        <= w_x;
            r_cnt      <= w_cnt;
            r_neg_q    <= w_neg_q;
            r_neg_r    <= w_neg_r;
            r_dz_pend  <= w_dz_pend;
            r_ovf_pend <= w_ovf_pend;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_quot     <= w_quot;
            r_rem      <= w_rem;
            r_dz       <= w_dz;
            r_ovf      <= w_ovf;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.div_zero  = r_dz;
    assign bus.overflow  = r_ovf;
endmodule
`default_nettype wire
